// File: rtl/stack_unit.sv
// Parametrised operand/return stack backed by a circular storage array.
// tos/nos/ros are read combinationally; depth tracking and sticky errors are registered.
module stack_unit #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int WRAP  = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       op_valid,
   input  logic [2:0]                 op,
   input  logic [WIDTH-1:0]           din,
   input  logic                       err_clr,
   output logic [WIDTH-1:0]           tos,
   output logic [WIDTH-1:0]           nos,
   output logic [WIDTH-1:0]           ros,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       empty,
   output logic                       full,
   output logic                       err_overflow,
   output logic                       err_underflow,
   output logic                       op_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = $clog2(DEPTH+1);

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_DUP     = 3'd3,
      OP_SWAP    = 3'd4,
      OP_ROT     = 3'd5,
      OP_POP2PUSH = 3'd6,
      OP_REPLACE = 3'd7
   } op_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    top_q, top_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             err_ov_q, err_ov_d;
   logic             err_un_q, err_un_d;
   logic             fault_q, fault_d;

   op_e              op_w;
   logic [PW-1:0]    idx0, idx1, idx2, idx3;
   logic [DW-1:0]    need;
   logic             full_w, underflow, overflow, exec;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? PW'(DEPTH-1) : p - 1'b1;
   endfunction

   assign op_w   = op_e'(op);
   assign idx0   = ptr_inc(top_q);
   assign idx1   = top_q;
   assign idx2   = ptr_dec(top_q);
   assign idx3   = ptr_dec(idx2);
   assign full_w = (depth_q == DW'(DEPTH));

   // Entries below the live depth are masked so stale storage never leaks out.
   assign tos           = (depth_q >= DW'(1)) ? mem_q[idx1] : '0;
   assign nos           = (depth_q >= DW'(2)) ? mem_q[idx2] : '0;
   assign ros           = (depth_q >= DW'(3)) ? mem_q[idx3] : '0;
   assign depth         = depth_q;
   assign empty         = (depth_q == '0);
   assign full          = full_w;
   assign err_overflow  = err_ov_q;
   assign err_underflow = err_un_q;
   assign op_fault      = fault_q;

   always_comb begin
      need = '0;
      case (op_w)
         OP_POP, OP_DUP, OP_REPLACE: need = DW'(1);
         OP_SWAP, OP_POP2PUSH:       need = DW'(2);
         OP_ROT:                     need = DW'(3);
         default:                    need = '0;
      endcase

      underflow = op_valid && (depth_q < need);
      overflow  = op_valid && !underflow && (op_w == OP_PUSH || op_w == OP_DUP) &&
                  full_w && (WRAP == 0);
      exec      = op_valid && !underflow && !overflow;

      mem_d   = mem_q;
      top_d   = top_q;
      depth_d = depth_q;

      if (exec) begin
         case (op_w)
            OP_PUSH, OP_DUP: begin
               mem_d[idx0] = (op_w == OP_PUSH) ? din : mem_q[idx1];
               top_d       = idx0;
               // When wrapping on a full stack the oldest entry is overwritten in place.
               depth_d     = full_w ? depth_q : depth_q + 1'b1;
            end
            OP_POP: begin
               top_d   = idx2;
               depth_d = depth_q - 1'b1;
            end
            OP_SWAP: begin
               mem_d[idx1] = mem_q[idx2];
               mem_d[idx2] = mem_q[idx1];
            end
            OP_ROT: begin
               mem_d[idx1] = mem_q[idx3];
               mem_d[idx2] = mem_q[idx1];
               mem_d[idx3] = mem_q[idx2];
            end
            OP_POP2PUSH: begin
               mem_d[idx2] = din;
               top_d       = idx2;
               depth_d     = depth_q - 1'b1;
            end
            OP_REPLACE: mem_d[idx1] = din;
            default: ;
         endcase
      end

      err_ov_d = overflow  | (err_ov_q & ~err_clr);
      err_un_d = underflow | (err_un_q & ~err_clr);
      fault_d  = underflow | overflow;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q    <= '0;
         depth_q  <= '0;
         err_ov_q <= 1'b0;
         err_un_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         top_q    <= top_d;
         depth_q  <= depth_d;
         err_ov_q <= err_ov_d;
         err_un_q <= err_un_d;
         fault_q  <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
